// File: rtl/accel_dot_pkg.sv
// Shared definitions for the accel_dot_lanes matrix-vector accelerator.
//
// Contents:
//   OUT_W   - width of a result beat on the output stream (32)
//   state_t - FSM state type, with constants ST_IN / ST_MAC / ST_OUT
//   sat32() - clamps a sign-extended 64-bit value to the signed 32-bit range
package accel_dot_pkg;

  localparam int OUT_W = 32;

  // Encoded as plain vectors so that older tools and netlists can match them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IN  = 2'd0;
  localparam state_t ST_MAC = 2'd1;
  localparam state_t ST_OUT = 2'd2;

  // Clamp to [-2^31, 2^31-1]. The accumulator is sign-extended to 64 bits first.
  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF) begin
      return 32'h7FFF_FFFF;
    end else if (v < 64'shFFFF_FFFF_8000_0000) begin
      return 32'h8000_0000;
    end else begin
      return v[31:0];
    end
  endfunction

endpackage

// File: rtl/accel_dot_lanes_if.sv
// AXI4-Stream style channel used for both the input and the output of accel_dot_lanes.
//
// Signals:
//   tdata  [DATA_W]  payload
//   tlast            final beat of a packet
//   tvalid           source has a beat
//   tready           sink accepts the beat
// Modports: master (drives tdata/tlast/tvalid), slave (drives tready).
interface accel_dot_lanes_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/dot_lane_reduce.sv
// Combinational lane reduction: LANES signed multipliers followed by a
// log2(LANES)-level adder tree.
//
// Ports:
//   x    in   LANES*DATA_W  packed operand lanes, lane l at [l*DATA_W +: DATA_W]
//   w    in   LANES*DATA_W  packed weight lanes, same layout
//   sum  out  ACC_W         signed sum of all lane products
module dot_lane_reduce #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic [LANES*DATA_W-1:0] x,
  input  logic [LANES*DATA_W-1:0] w,
  output logic signed [ACC_W-1:0] sum
);

  localparam int PROD_W = 2 * DATA_W;

  // Heap-ordered tree: leaves live at [LANES .. 2*LANES-1], node n = child 2n + child 2n+1,
  // and the root is node 1. With LANES == 1 the single leaf is the root.
  logic signed [ACC_W-1:0] node_s [1:2*LANES-1];

  for (genvar l = 0; l < LANES; l++) begin : g_mul
    logic signed [PROD_W-1:0] prod_s;
    // Operands are widened before the multiply so the full-width product is kept.
    assign prod_s = PROD_W'($signed(x[l*DATA_W +: DATA_W])) *
                    PROD_W'($signed(w[l*DATA_W +: DATA_W]));
    assign node_s[LANES+l] = ACC_W'(prod_s);
  end

  for (genvar n = LANES - 1; n >= 1; n--) begin : g_add
    assign node_s[n] = node_s[2*n] + node_s[2*n+1];
  end

  assign sum = node_s[1];

endmodule

// File: rtl/accel_dot_lanes.sv
// Integer matrix-vector accelerator: y[c] = sum_r x[r] * W[r][c].
// Each input beat carries LANES elements of x. After a beat is accepted, one
// weight column is folded per cycle into COLS accumulators. When the vector is
// complete, the COLS results are streamed out in column order.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_axis    slave   LANES*DATA_W-bit input stream; tlast marks the final beat of x
//   weights    in   signed DATA_W x [ROWS][COLS]; must be stable while the block is busy
//   out_axis   master  32-bit result stream; tlast is set with y[COLS-1]
//   tlast_err  out  one-cycle pulse when the input tlast disagrees with the beat count
//
// Configuration macro ACCEL_DOT_SAT_EN: when defined, results are clamped to the
// signed 32-bit range. Otherwise the low 32 bits of the accumulator are output.
module accel_dot_lanes
  import accel_dot_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 4,
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  accel_dot_lanes_if.slave         in_axis,
  input  logic signed [DATA_W-1:0] weights [ROWS][COLS],
  accel_dot_lanes_if.master        out_axis,
  output logic                     tlast_err
);

  localparam int BEATS  = ROWS / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (ROWS % LANES != 0) begin : g_bad_rows
    $error("accel_dot_lanes: ROWS must be a multiple of LANES");
  end
  if ((LANES < 1) || (LANES > 16) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
    $error("accel_dot_lanes: LANES must be a power of two in 1..16");
  end
  if ((ACC_W > 64) || (ACC_W < 2 * DATA_W)) begin : g_bad_acc
    $error("accel_dot_lanes: ACC_W must be in 2*DATA_W..64");
  end

  state_t                  state_r;
  state_t                  state_s;
  logic [BEAT_W-1:0]       beat_r;
  logic [COL_W-1:0]        col_r;
  logic [COL_W-1:0]        ocol_r;
  logic [COL_W-1:0]        ocol_nxt_s;
  logic [LANES*DATA_W-1:0] xreg_r;
  logic                    last_flag_r;
  logic signed [ACC_W-1:0] acc_r [COLS];

  logic                    in_tready_r;
  logic                    tlast_err_r;
  logic                    out_tvalid_r;
  logic                    out_tlast_r;
  logic [OUT_W-1:0]        out_tdata_r;

  logic                    in_hs_s;
  logic                    out_hs_s;
  logic                    col_last_s;
  logic                    ocol_last_s;
  logic                    last_beat_s;
  logic                    mac_done_s;
  logic                    tlast_bad_s;
  logic [LANES*DATA_W-1:0] w_slice_s;
  logic signed [ACC_W-1:0] lane_sum_s;
  logic signed [ACC_W-1:0] first_acc_s;

  // Result formatting: clamp or wrap to 32 bits, depending on the build.
  function automatic logic [OUT_W-1:0] fmt(input logic signed [ACC_W-1:0] a);
    logic signed [63:0] wide;
    wide = 64'(a);
`ifdef ACCEL_DOT_SAT_EN
    return sat32(wide);
`else
    return wide[OUT_W-1:0];
`endif
  endfunction

  assign in_hs_s     = in_tready_r & in_axis.tvalid;
  assign out_hs_s    = out_tvalid_r & out_axis.tready;
  assign col_last_s  = (col_r == COL_W'(COLS - 1));
  assign ocol_last_s = (ocol_r == COL_W'(COLS - 1));
  assign ocol_nxt_s  = ocol_r + COL_W'(1);
  // A vector also ends early when the source flagged tlast on the latched beat.
  assign last_beat_s = (beat_r == BEAT_W'(BEATS - 1)) | last_flag_r;
  assign mac_done_s  = (state_r == ST_MAC) & col_last_s;

  // tlast is expected exactly on the final beat; both early and missing tlast are flagged.
  always_comb begin
    tlast_bad_s = 1'b0;
    if (in_axis.tlast) begin
      tlast_bad_s = (beat_r != BEAT_W'(BEATS - 1));
    end else begin
      tlast_bad_s = (beat_r == BEAT_W'(BEATS - 1));
    end
  end

  // Gather weight column col_r for the rows covered by the current beat.
  always_comb begin
    w_slice_s = '0;
    for (int l = 0; l < LANES; l++) begin
      w_slice_s[l*DATA_W +: DATA_W] = weights[ROW_W'(int'(beat_r) * LANES + l)][col_r];
    end
  end

  dot_lane_reduce #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_reduce (
    .x   (xreg_r),
    .w   (w_slice_s),
    .sum (lane_sum_s)
  );

  // With one column, acc[0] is still being updated in the cycle that loads the first output.
  always_comb begin
    first_acc_s = acc_r[0];
    if (COLS == 1) begin
      first_acc_s = acc_r[0] + lane_sum_s;
    end else begin
      first_acc_s = acc_r[0];
    end
  end

  // Next-state logic for the input / multiply-accumulate / output sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IN: begin
        if (in_hs_s) begin
          state_s = ST_MAC;
        end else begin
          state_s = ST_IN;
        end
      end
      ST_MAC: begin
        if (col_last_s) begin
          state_s = last_beat_s ? ST_OUT : ST_IN;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_OUT: begin
        if (out_hs_s && ocol_last_s) begin
          state_s = ST_IN;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: state_s = ST_IN;
    endcase
  end

  // FSM state, beat/column counters, operand register and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IN;
      beat_r      <= '0;
      col_r       <= '0;
      ocol_r      <= '0;
      xreg_r      <= '0;
      last_flag_r <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        acc_r[c] <= '0;
      end
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IN: begin
          if (in_hs_s) begin
            xreg_r      <= in_axis.tdata;
            last_flag_r <= in_axis.tlast;
            col_r       <= '0;
          end else begin
            xreg_r <= xreg_r;
          end
        end
        ST_MAC: begin
          acc_r[col_r] <= acc_r[col_r] + lane_sum_s;
          if (col_last_s) begin
            col_r <= '0;
            if (last_beat_s) begin
              ocol_r <= '0;
            end else begin
              beat_r <= beat_r + BEAT_W'(1);
            end
          end else begin
            col_r <= col_r + COL_W'(1);
          end
        end
        ST_OUT: begin
          if (out_hs_s) begin
            if (ocol_last_s) begin
              // Vector finished: clear the sums so the next vector starts from zero.
              for (int c = 0; c < COLS; c++) begin
                acc_r[c] <= '0;
              end
              beat_r      <= '0;
              ocol_r      <= '0;
              last_flag_r <= 1'b0;
            end else begin
              ocol_r <= ocol_nxt_s;
            end
          end else begin
            ocol_r <= ocol_r;
          end
        end
        default: begin
          state_r <= ST_IN;
        end
      endcase
    end
  end

  // Input ready and the tlast mismatch pulse (pulse appears the cycle after the handshake).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_tready_r <= 1'b0;
      tlast_err_r <= 1'b0;
    end else begin
      in_tready_r <= (state_s == ST_IN);
      if (in_hs_s) begin
        tlast_err_r <= tlast_bad_s;
      end else begin
        tlast_err_r <= 1'b0;
      end
    end
  end

  // Output beat register: the first column is loaded when the vector completes, and the
  // register advances by one column on each accepted beat. It holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tvalid_r <= 1'b0;
      out_tlast_r  <= 1'b0;
      out_tdata_r  <= '0;
    end else if (mac_done_s && last_beat_s) begin
      out_tvalid_r <= 1'b1;
      out_tlast_r  <= (COLS == 1) ? 1'b1 : 1'b0;
      out_tdata_r  <= fmt(first_acc_s);
    end else if (out_hs_s) begin
      if (ocol_last_s) begin
        out_tvalid_r <= 1'b0;
        out_tlast_r  <= 1'b0;
        out_tdata_r  <= '0;
      end else begin
        out_tvalid_r <= 1'b1;
        out_tlast_r  <= (ocol_nxt_s == COL_W'(COLS - 1));
        out_tdata_r  <= fmt(acc_r[ocol_nxt_s]);
      end
    end else begin
      out_tvalid_r <= out_tvalid_r;
      out_tlast_r  <= out_tlast_r;
      out_tdata_r  <= out_tdata_r;
    end
  end

  assign in_axis.tready  = in_tready_r;
  assign out_axis.tvalid = out_tvalid_r;
  assign out_axis.tlast  = out_tlast_r;
  assign out_axis.tdata  = out_tdata_r;
  assign tlast_err       = tlast_err_r;

endmodule
